ctrl_img_feed: RTL and testbench

//  Source side of the begin/valid/end pixel stream consumed by the conv controller.
//  On req, reads n_in image channels of img_size x img_size pixels from image memory.

---
 rtl/ctrl_img_feed_pkg.sv | 16 +
 rtl/ctrl_img_feed_delay_line.sv | 30 +++
 rtl/ctrl_img_feed.sv | 150 +++++++++++++++
 tb/tb_ctrl_img_feed.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_img_feed_pkg.sv
// Shared widths and FSM encoding for the image feed block.
package ctrl_img_feed_pkg;
  localparam int DWIDTH  = 16;
  localparam int IMGADDR = 12;
  localparam int LWIDTH  = 10;
  localparam int WAIT_W  = 16;
  localparam int TAG_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEGIN = 3'd1,
    S_READ  = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/ctrl_img_feed_delay_line.sv
// Fixed-depth shift register that aligns stream tags with memory read data.
module ctrl_img_feed_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [W-1:0] q_reg;
    logic [W-1:0] stage_d;

    if (gi == 0) begin : g_first
      assign stage_d = din;
    end else begin : g_next
      assign stage_d = g_stage[gi-1].q_reg;
    end

    always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) q_reg <= '0;
      else       q_reg <= stage_d;
    end
  end

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/ctrl_img_feed.sv
// Reads n_in square image channels from memory and emits them as a tagged
// begin/valid/end pixel stream, with an idle gap between channels and a done ack.
module ctrl_img_feed
  import ctrl_img_feed_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int GAP    = 6
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [LWIDTH-1:0]  w_img_size,
  input  logic [LWIDTH-1:0]  w_n_in,
  input  logic [IMGADDR-1:0] w_img_base,
  output logic               mem_img_re,
  output logic [IMGADDR-1:0] mem_img_addr,
  input  logic [DWIDTH-1:0]  mem_img_rdata,
  output logic               out_begin,
  output logic               out_valid,
  output logic               out_end,
  output logic [DWIDTH-1:0]  out_pixel,
  output logic               first_input,
  output logic               last_input,
  output logic               ack
);

  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP - 1);
  localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [LWIDTH-1:0] L_ONE      = LWIDTH'(1);

  state_t             state_reg, state_next;
  logic [LWIDTH-1:0]  size_reg, n_in_reg, x_reg, y_reg, ch_reg;
  logic [IMGADDR-1:0] addr_reg;
  logic [WAIT_W-1:0]  wait_reg;
  logic               ack_reg;

  logic               re, begin_mark, ack_set;
  logic               px_last, ch_first, ch_last;
  logic [TAG_W-1:0]   tag_in, tag_out;

  assign px_last  = (x_reg == size_reg - L_ONE) && (y_reg == size_reg - L_ONE);
  assign ch_first = (ch_reg == '0);
  assign ch_last  = (ch_reg == n_in_reg - L_ONE);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    re         = 1'b0;
    begin_mark = 1'b0;
    ack_set    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          // An empty run still walks through DRAIN so ack timing stays uniform.
          if (w_img_size == '0 || w_n_in == '0) state_next = S_DRAIN;
          else                                  state_next = S_BEGIN;
        end
      end
      S_BEGIN: begin
        begin_mark = 1'b1;
        state_next = S_READ;
      end
      S_READ: begin
        re = 1'b1;
        if (px_last) begin
          if (ch_last)       state_next = S_DRAIN;
          else if (GAP != 0) state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (wait_reg == GAP_LAST) state_next = S_READ;
      end
      S_DRAIN: begin
        if (wait_reg == DRAIN_LAST) begin
          state_next = S_IDLE;
          ack_set    = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      size_reg <= '0;
      n_in_reg <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
      ch_reg   <= '0;
      addr_reg <= '0;
      wait_reg <= '0;
      ack_reg  <= 1'b0;
    end else begin
      ack_reg <= ack_set;

      if (state_next != state_reg)                        wait_reg <= '0;
      else if (state_reg == S_GAP || state_reg == S_DRAIN) wait_reg <= wait_reg + WAIT_W'(1);

      if (state_reg == S_IDLE && req) begin
        size_reg <= w_img_size;
        n_in_reg <= w_n_in;
        addr_reg <= w_img_base;
        x_reg    <= '0;
        y_reg    <= '0;
        ch_reg   <= '0;
      end else if (state_reg == S_READ) begin
        // Channels are contiguous, so a running address replaces base + ch*size*size.
        addr_reg <= addr_reg + IMGADDR'(1);
        if (x_reg == size_reg - L_ONE) begin
          x_reg <= '0;
          if (y_reg == size_reg - L_ONE) begin
            y_reg  <= '0;
            ch_reg <= ch_reg + L_ONE;
          end else begin
            y_reg <= y_reg + L_ONE;
          end
        end else begin
          x_reg <= x_reg + L_ONE;
        end
      end
    end
  end

  assign tag_in = {begin_mark, re, re & ch_first, re & ch_last, re & px_last & ch_last};

  ctrl_img_feed_delay_line #(
    .W     (TAG_W),
    .DEPTH (RD_LAT)
  ) u_tag_delay (
    .clk  (clk),
    .xrst (xrst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign out_begin    = tag_out[4];
  assign out_valid    = tag_out[3];
  assign first_input  = tag_out[2];
  assign last_input   = tag_out[1];
  assign out_end      = tag_out[0];
  assign out_pixel    = out_valid ? mem_img_rdata : '0;
  assign mem_img_re   = re;
  assign mem_img_addr = re ? addr_reg : '0;
  assign ack          = ack_reg;

endmodule

// File: tb/tb_ctrl_img_feed.sv
// Directed bench: two instances (read latency 1 and 2) share stimulus and are
// checked every cycle against a precomputed event schedule plus literal timings.
module tb_ctrl_img_feed;
  import ctrl_img_feed_pkg::*;

  localparam int GAP_P = 6;
  localparam int MAXC  = 1024;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic req = 1'b0;
  logic [LWIDTH-1:0]  w_img_size = '0;
  logic [LWIDTH-1:0]  w_n_in = '0;
  logic [IMGADDR-1:0] w_img_base = '0;

  logic re0, re1, beg0, beg1, val0, val1, end0, end1, fi0, fi1, la0, la1, ack0, ack1;
  logic [IMGADDR-1:0] addr0, addr1;
  logic [DWIDTH-1:0]  rdata0, rdata1, rd1_stage, pix0, pix1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Flag bit order: 6 re, 5 begin, 4 valid, 3 first, 2 last, 1 end, 0 ack
  logic [6:0]         exp_flags [2][MAXC];
  logic [IMGADDR-1:0] exp_addr  [2][MAXC];
  logic [DWIDTH-1:0]  exp_pix   [2][MAXC];
  logic [6:0]         act_flags [2];
  logic [IMGADDR-1:0] act_addr  [2];
  logic [DWIDTH-1:0]  act_pix   [2];

  assign act_flags[0] = {re0, beg0, val0, fi0, la0, end0, ack0};
  assign act_flags[1] = {re1, beg1, val1, fi1, la1, end1, ack1};
  assign act_addr[0]  = addr0;
  assign act_addr[1]  = addr1;
  assign act_pix[0]   = pix0;
  assign act_pix[1]   = pix1;

  ctrl_img_feed #(.RD_LAT(1), .GAP(GAP_P)) dut0 (
    .clk(clk), .xrst(xrst), .req(req), .w_img_size(w_img_size), .w_n_in(w_n_in),
    .w_img_base(w_img_base), .mem_img_re(re0), .mem_img_addr(addr0), .mem_img_rdata(rdata0),
    .out_begin(beg0), .out_valid(val0), .out_end(end0), .out_pixel(pix0),
    .first_input(fi0), .last_input(la0), .ack(ack0)
  );

  ctrl_img_feed #(.RD_LAT(2), .GAP(GAP_P)) dut1 (
    .clk(clk), .xrst(xrst), .req(req), .w_img_size(w_img_size), .w_n_in(w_n_in),
    .w_img_base(w_img_base), .mem_img_re(re1), .mem_img_addr(addr1), .mem_img_rdata(rdata1),
    .out_begin(beg1), .out_valid(val1), .out_end(end1), .out_pixel(pix1),
    .first_input(fi1), .last_input(la1), .ack(ack1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Image memory holds mem[a] = a
  always @(posedge clk) begin
    rdata0    <= DWIDTH'(addr0);
    rd1_stage <= DWIDTH'(addr1);
    rdata1    <= rd1_stage;
  end

  task automatic check(input string name, input int d, input int c,
                       input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=0x%0h required=0x%0h", name, d, c, act, req_v);
    end
  endtask

  // Expected schedule of one run, from the stream timing rules.
  task automatic plan(input int d, input int lat, input int c0, input int s, input int n,
                      input int base);
    int ss, t, v, a, last_v;
    ss = s * s;
    last_v = 0;
    if (s == 0 || n == 0) begin
      exp_flags[d][c0 + lat + 1][0] = 1'b1;
      return;
    end
    exp_flags[d][c0 + 1 + lat][5] = 1'b1;
    for (int ch = 0; ch < n; ch++) begin
      for (int i = 0; i < ss; i++) begin
        t = c0 + 2 + ch * (ss + GAP_P) + i;
        a = (base + ch * ss + i) % 4096;
        v = t + lat;
        exp_flags[d][t][6] = 1'b1;
        exp_addr[d][t]     = IMGADDR'(a);
        exp_flags[d][v][4] = 1'b1;
        exp_flags[d][v][3] = (ch == 0);
        exp_flags[d][v][2] = (ch == n - 1);
        exp_pix[d][v]      = DWIDTH'(a);
        last_v = v;
      end
    end
    exp_flags[d][last_v][1]     = 1'b1;
    exp_flags[d][last_v + 1][0] = 1'b1;
  endtask

  task automatic clear_from(input int r);
    for (int d = 0; d < 2; d++)
      for (int c = r; c < MAXC; c++) begin
        exp_flags[d][c] = '0;
        exp_addr[d][c]  = '0;
        exp_pix[d][c]   = '0;
      end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        check("flags", d, cyc, 32'(act_flags[d]), 32'(exp_flags[d][cyc]));
        if (exp_flags[d][cyc][6]) check("addr", d, cyc, 32'(act_addr[d]), 32'(exp_addr[d][cyc]));
        if (exp_flags[d][cyc][4]) check("pixel", d, cyc, 32'(act_pix[d]), 32'(exp_pix[d][cyc]));
      end
    end
  end

  // Per-run event log, restarted whenever run_id changes
  int run_id = 0;
  int seen_id = 0;
  int lg_begin[2], lg_fv[2], lg_end[2], lg_ack[2];
  int lg_beg_cnt[2], lg_v_cnt[2], lg_end_cnt[2], lg_ack_cnt[2], lg_re_cnt[2];
  logic [IMGADDR-1:0] lg_addr[2][16];

  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      for (int d = 0; d < 2; d++) begin
        lg_begin[d] = -1; lg_fv[d] = -1; lg_end[d] = -1; lg_ack[d] = -1;
        lg_beg_cnt[d] = 0; lg_v_cnt[d] = 0; lg_end_cnt[d] = 0; lg_ack_cnt[d] = 0;
        lg_re_cnt[d] = 0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (act_flags[d][5]) begin lg_begin[d] = cyc; lg_beg_cnt[d]++; end
      if (act_flags[d][4]) begin
        if (lg_v_cnt[d] == 0) lg_fv[d] = cyc;
        lg_v_cnt[d]++;
      end
      if (act_flags[d][1]) begin lg_end[d] = cyc; lg_end_cnt[d]++; end
      if (act_flags[d][0]) begin lg_ack[d] = cyc; lg_ack_cnt[d]++; end
      if (act_flags[d][6]) begin
        if (lg_re_cnt[d] < 16) lg_addr[d][lg_re_cnt[d]] = act_addr[d];
        lg_re_cnt[d]++;
      end
    end
  end

  task automatic start_run(input int s, input int n, input int base, output int c0);
    @(negedge clk);
    c0 = cyc;
    run_id++;
    w_img_size = LWIDTH'(s);
    w_n_in     = LWIDTH'(n);
    w_img_base = IMGADDR'(base);
    req        = 1'b1;
    plan(0, 1, c0, s, n, base);
    plan(1, 2, c0, s, n, base);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int c0, r;

  initial begin
    clear_from(0);
    settle(3);
    check("rst_flags", 0, cyc, 32'(act_flags[0]), 32'd0);
    check("rst_addr", 0, cyc, 32'(addr0), 32'd0);
    @(negedge clk);
    xrst = 1'b1;
    settle(2);

    // 3x3, one channel, base 0x010
    start_run(3, 1, 'h010, c0);
    settle(16);
    check("t1_begin", 0, c0, 32'(lg_begin[0] - c0), 32'd2);
    check("t1_first_valid", 0, c0, 32'(lg_fv[0] - c0), 32'd3);
    check("t1_end", 0, c0, 32'(lg_end[0] - c0), 32'd11);
    check("t1_ack", 0, c0, 32'(lg_ack[0] - c0), 32'd12);
    check("t1_valids", 0, c0, 32'(lg_v_cnt[0]), 32'd9);
    check("t1_addr0", 0, c0, 32'(lg_addr[0][0]), 32'h010);
    check("t1_end_lat2", 1, c0, 32'(lg_end[1] - c0), 32'd12);
    check("t1_ack_lat2", 1, c0, 32'(lg_ack[1] - c0), 32'd13);

    // 2x2, two channels, gap between them
    start_run(2, 2, 0, c0);
    settle(22);
    check("t2_valids", 0, c0, 32'(lg_v_cnt[0]), 32'd8);
    check("t2_begins", 0, c0, 32'(lg_beg_cnt[0]), 32'd1);
    check("t2_ends", 0, c0, 32'(lg_end_cnt[0]), 32'd1);
    check("t2_span", 0, c0, 32'(lg_end[0] - lg_fv[0]), 32'd13);
    for (int i = 0; i < 8; i++) check("t2_addr", 0, i, 32'(lg_addr[0][i]), 32'(i));

    // Empty runs: n_in = 0, then size = 0
    start_run(2, 0, 5, c0);
    settle(6);
    check("t3_re", 0, c0, 32'(lg_re_cnt[0]), 32'd0);
    check("t3_valid", 0, c0, 32'(lg_v_cnt[0]), 32'd0);
    check("t3_begin", 0, c0, 32'(lg_beg_cnt[0]), 32'd0);
    check("t3_ack", 0, c0, 32'(lg_ack[0] - c0), 32'd2);
    check("t3_ack_lat2", 1, c0, 32'(lg_ack[1] - c0), 32'd3);
    start_run(0, 3, 5, c0);
    settle(6);
    check("t3b_re", 0, c0, 32'(lg_re_cnt[0]), 32'd0);
    check("t3b_valid", 1, c0, 32'(lg_v_cnt[1]), 32'd0);
    check("t3b_ack", 0, c0, 32'(lg_ack[0] - c0), 32'd2);

    // Stray req mid-stream must be ignored
    start_run(3, 1, 'h100, c0);
    repeat (3) @(negedge clk);
    w_img_size = LWIDTH'(4);
    w_n_in     = LWIDTH'(2);
    w_img_base = IMGADDR'('h300);
    req        = 1'b1;
    @(negedge clk);
    req = 1'b0;
    settle(16);
    check("t4_acks", 0, c0, 32'(lg_ack_cnt[0]), 32'd1);
    check("t4_acks_lat2", 1, c0, 32'(lg_ack_cnt[1]), 32'd1);
    check("t4_valids", 0, c0, 32'(lg_v_cnt[0]), 32'd9);
    check("t4_addr0", 0, c0, 32'(lg_addr[0][0]), 32'h100);

    // Address wrap at the top of image memory
    start_run(2, 1, 'hFFE, c0);
    settle(10);
    check("t5_addr0", 0, c0, 32'(lg_addr[0][0]), 32'hFFE);
    check("t5_addr1", 0, c0, 32'(lg_addr[0][1]), 32'hFFF);
    check("t5_addr2", 0, c0, 32'(lg_addr[0][2]), 32'h000);
    check("t5_addr3", 0, c0, 32'(lg_addr[0][3]), 32'h001);

    // Reset during READ abandons the run, then a clean rerun
    start_run(3, 2, 'h020, c0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    xrst = 1'b0;
    r = cyc;
    clear_from(r);
    #1;
    check("t6_rst_flags0", 0, r, 32'(act_flags[0]), 32'd0);
    check("t6_rst_flags1", 1, r, 32'(act_flags[1]), 32'd0);
    check("t6_rst_pix1", 1, r, 32'(pix1), 32'd0);
    settle(3);
    @(negedge clk);
    xrst = 1'b1;
    settle(4);
    check("t6_no_ack0", 0, r, 32'(lg_ack_cnt[0]), 32'd0);
    check("t6_no_ack1", 1, r, 32'(lg_ack_cnt[1]), 32'd0);
    start_run(2, 1, 'h040, c0);
    settle(12);
    check("t6_begin_lat2", 1, c0, 32'(lg_begin[1] - c0), 32'd3);
    check("t6_fv_lat2", 1, c0, 32'(lg_fv[1] - c0), 32'd4);
    check("t6_end_lat2", 1, c0, 32'(lg_end[1] - c0), 32'd7);
    check("t6_ack_lat2", 1, c0, 32'(lg_ack[1] - c0), 32'd8);
    check("t6_ack_lat1", 0, c0, 32'(lg_ack[0] - c0), 32'd7);
    check("t6_valids", 1, c0, 32'(lg_v_cnt[1]), 32'd4);

    settle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
